// File: rtl/one_to16_tdm_demux.sv
// rtl/one_to16_tdm_demux.sv - 1-to-16 serial TDM demultiplexer with frame/gap checking
module one_to16_tdm_demux #(
    parameter int GAP_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        frame_start,
    output logic [15:0] y,
    output logic        y_valid,
    output logic [3:0]  ch,
    output logic        busy,
    output logic        frame_err
);

    // Wide enough to hold GAP_LIMIT+1 with headroom so the saturation point
    // is never reached before the limit compare can fire.
    localparam int GW = $clog2(GAP_LIMIT + 2) + 1;
    localparam logic [GW-1:0] GAP_MAX  = {GW{1'b1}};
    localparam logic [GW-1:0] GAP_TRIP = GW'(GAP_LIMIT + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      ch_q, ch_d;
    logic [15:0]     lanes_q, lanes_d;
    logic [15:0]     y_q, y_d;
    logic            y_valid_q, y_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [GW-1:0]   gap_q, gap_d;

    // Next-state logic: frame assembly, completion, restart and gap abort
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        lanes_d     = lanes_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        gap_d       = gap_q;

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (din_valid && frame_start) begin
                    lanes_d = {15'b0, din};
                    ch_d    = 4'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    gap_d = '0;
                    if (frame_start) begin
                        // Restart mid-frame: drop the partial frame, keep this bit as channel 0
                        frame_err_d = 1'b1;
                        lanes_d     = {15'b0, din};
                        ch_d        = 4'd1;
                    end else if (ch_q == 4'd15) begin
                        // Final bit goes straight into y so it is not lost
                        y_d       = {din, lanes_q[14:0]};
                        y_valid_d = 1'b1;
                        lanes_d   = '0;
                        ch_d      = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        lanes_d[ch_q] = din;
                        ch_d          = ch_q + 4'd1;
                    end
                end else begin
                    if (gap_q != GAP_MAX) begin
                        gap_d = gap_q + GW'(1);
                    end
                    if ((GAP_LIMIT > 0) && (gap_d == GAP_TRIP)) begin
                        frame_err_d = 1'b1;
                        lanes_d     = '0;
                        ch_d        = 4'd0;
                        gap_d       = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = 4'd0;
                lanes_d = '0;
                gap_d   = '0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= 4'd0;
            lanes_q     <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            lanes_q     <= lanes_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            frame_err_q <= frame_err_d;
            gap_q       <= gap_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign ch        = ch_q;
    assign busy      = (state_q == COLLECT);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_one_to16_tdm_demux.sv
// tb/tb_one_to16_tdm_demux.sv - self-checking bench for one_to16_tdm_demux
module tb_one_to16_tdm_demux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic frame_start = 1'b0;

    logic [15:0] y0, y2;
    logic        yv0, yv2, busy0, busy2, err0, err2;
    logic [3:0]  ch0, ch2;

    always #5 clk = ~clk;

    one_to16_tdm_demux #(.GAP_LIMIT(0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .y(y0), .y_valid(yv0), .ch(ch0),
        .busy(busy0), .frame_err(err0)
    );

    one_to16_tdm_demux #(.GAP_LIMIT(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .y(y2), .y_valid(yv2), .ch(ch2),
        .busy(busy2), .frame_err(err2)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int errs0 = 0;
    int errs2 = 0;
    int exp_errs0 = 0;
    int exp_errs2 = 0;
    logic [15:0] q0[$];
    logic [15:0] q2[$];
    int yv_cyc0[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every y_valid pulse must match the oldest queued frame
    always @(negedge clk) begin
        if (yv0) begin
            check("yv0_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) check("y0_sb", y0, q0.pop_front());
            check("excl0", err0, 1'b0);
            yv_cyc0.push_back(cyc);
        end
        if (yv2) begin
            check("yv2_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) check("y2_sb", y2, q2.pop_front());
            check("excl2", err2, 1'b0);
        end
        if (err0) errs0++;
        if (err2) errs2++;
    end

    task automatic step(input logic d, input logic v, input logic fs);
        din = d;
        din_valid = v;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'($urandom), 1'b0, 1'b1);
    endtask

    task automatic send_bits(input logic [15:0] pat, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) step(pat[k], 1'b1, k == 0);
    endtask

    typedef struct {
        logic [15:0] pat;
        int          gap_ch;
        int          gap_len;
        logic [15:0] exp_y0;
        logic [15:0] exp_y2;
        logic        exp_abort2;
    } row_t;

    row_t rows[5];

    initial begin
        logic [15:0] y2_before;

        rows[0] = '{16'hA5C3, -1, 0, 16'hA5C3, 16'hA5C3, 1'b0};
        rows[1] = '{16'hA5C3,  7, 3, 16'hA5C3, 16'hA5C3, 1'b1};
        rows[2] = '{16'h0000, -1, 0, 16'h0000, 16'h0000, 1'b0};
        rows[3] = '{16'hFFFF,  0, 2, 16'hFFFF, 16'hFFFF, 1'b0};
        rows[4] = '{16'h1234, 10, 1, 16'h1234, 16'h1234, 1'b0};

        // Reset state
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("rst_y", y0, 16'h0000);
        check("rst_ch", ch0, 4'd0);
        check("rst_busy", busy0, 1'b0);
        check("rst_yv", yv0, 1'b0);
        check("rst_err", err0, 1'b0);
        rst = 1'b0;

        // Idle discards valid bits without frame_start
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        check("idle_ch", ch0, 4'd0);
        check("idle_busy", busy0, 1'b0);

        // Table-driven frames, optional mid-frame gap
        for (int r = 0; r < 5; r++) begin
            q0.push_back(rows[r].pat);
            if (!rows[r].exp_abort2) q2.push_back(rows[r].pat);
            else exp_errs2++;
            for (int k = 0; k < 16; k++) begin
                step(rows[r].pat[k], 1'b1, k == 0);
                if (k == rows[r].gap_ch)
                    for (int g = 0; g < rows[r].gap_len; g++) idle_step();
                if (k == 4) check($sformatf("row%0d_ch_mid", r), ch0, 4'd5);
            end
            check($sformatf("row%0d_yv0_lat", r), yv0, 1'b1);
            check($sformatf("row%0d_yv2", r), yv2, !rows[r].exp_abort2);
            check($sformatf("row%0d_y0", r), y0, rows[r].exp_y0);
            check($sformatf("row%0d_y2", r), y2, rows[r].exp_y2);
            check($sformatf("row%0d_ch", r), ch0, 4'd0);
            check($sformatf("row%0d_busy", r), busy0, 1'b0);
            idle_step();
            check($sformatf("row%0d_yv0_pulse", r), yv0, 1'b0);
        end

        // Gap of 3 after channel 4: GAP_LIMIT=2 aborts, GAP_LIMIT=0 keeps going
        y2_before = y2;
        send_bits(16'h5A5A, 0, 4);
        idle_step();
        idle_step();
        check("gap_no_err_early", err2, 1'b0);
        idle_step();
        exp_errs2++;
        check("gap_err2", err2, 1'b1);
        check("gap_ch2", ch2, 4'd0);
        check("gap_busy2", busy2, 1'b0);
        check("gap_err0", err0, 1'b0);
        check("gap_ch0_hold", ch0, 4'd5);
        q0.push_back(16'h5A5A);
        send_bits(16'h5A5A, 5, 15);
        check("gap_y0", y0, 16'h5A5A);
        check("gap_y2_hold", y2, y2_before);
        check("gap_yv2", yv2, 1'b0);

        // Restart at channel 9, then a full FFFF frame
        send_bits(16'h0000, 0, 8);
        check("rs_ch", ch0, 4'd9);
        q0.push_back(16'hFFFF);
        q2.push_back(16'hFFFF);
        send_bits(16'hFFFF, 0, 0);
        exp_errs0++;
        exp_errs2++;
        check("rs_err0", err0, 1'b1);
        check("rs_err2", err2, 1'b1);
        check("rs_ch1", ch0, 4'd1);
        check("rs_y_hold", y0, 16'h5A5A);
        send_bits(16'hFFFF, 1, 15);
        check("rs_y0", y0, 16'hFFFF);
        check("rs_yv0", yv0, 1'b1);

        // Reset at channel 12 discards silently
        send_bits(16'hBEEF, 0, 11);
        check("mr_ch", ch0, 4'd12);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("mr_y", y0, 16'h0000);
        check("mr_ch0", ch0, 4'd0);
        check("mr_yv", yv0, 1'b0);
        check("mr_err", err0, 1'b0);
        check("mr_busy", busy0, 1'b0);
        rst = 1'b0;
        q0.push_back(16'h0001);
        q2.push_back(16'h0001);
        send_bits(16'h0001, 0, 15);
        check("mr_y0_next", y0, 16'h0001);
        check("mr_y2_next", y2, 16'h0001);

        // Back-to-back frames, no idle cycle between
        idle_step();
        yv_cyc0.delete();
        q0.push_back(16'h1234);
        q2.push_back(16'h1234);
        q0.push_back(16'h8001);
        q2.push_back(16'h8001);
        send_bits(16'h1234, 0, 15);
        check("b2b_y_first", y0, 16'h1234);
        send_bits(16'h8001, 0, 15);
        idle_step();
        check("b2b_pulses", yv_cyc0.size(), 2);
        if (yv_cyc0.size() == 2) check("b2b_spacing", yv_cyc0[1] - yv_cyc0[0], 16);
        check("b2b_y0", y0, 16'h8001);
        check("b2b_y2", y2, 16'h8001);

        idle_step();
        check("errs0_total", errs0, exp_errs0);
        check("errs2_total", errs2, exp_errs2);
        check("q0_drained", q0.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/one_to16_tdm_demux.md
ONE_TO16_TDM_DEMUX -- requirements
Module: one_to16_tdm_demux

Interface
REQ-001 SHALL have parameter GAP_LIMIT, default 0, max consecutive idle cycles (din_valid low) tolerated mid-frame; 0 disables the gap check.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port din  input  1  serial data bit, time-division multiplexed, channel 0 first.
REQ-005 SHALL have port din_valid  input  1  din qualifier; a bit is accepted only in a cycle with din_valid=1.
REQ-006 SHALL have port frame_start  input  1  marks the accepted bit as channel 0 of a new frame; ignored when din_valid=0.
REQ-007 SHALL have port y  output  16  demultiplexed word; y[k] holds the channel-k bit of the last complete frame.
REQ-008 SHALL have port y_valid  output  1  one-cycle pulse when y is updated.
REQ-009 SHALL have port ch  output  4  channel index the next accepted bit will be routed to.
REQ-010 SHALL have port busy  output  1  high while in state COLLECT.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on an aborted frame.

Function
REQ-012 SHALL implement states IDLE and COLLECT.
REQ-013 IDLE: bits with din_valid=1, frame_start=0 SHALL be discarded; ch SHALL read 0.
REQ-014 IDLE, din_valid=1 and frame_start=1: bit SHALL be stored to internal lane 0, ch SHALL become 1, state SHALL go to COLLECT.
REQ-015 COLLECT, din_valid=1, frame_start=0: bit SHALL be stored to internal lane ch, ch SHALL increment by 1.
REQ-016 COLLECT, accepted bit at ch=15: internal lanes SHALL be copied to y and y_valid SHALL pulse in the next cycle (latency 1 cycle after the 16th accepted bit); ch SHALL wrap to 0; state SHALL go to IDLE.
REQ-017 The frame-completing bit of REQ-016 SHALL be stored to y[15] in the same update (no bit lost).
REQ-018 COLLECT, din_valid=1, frame_start=1 at any ch (1..15): frame_err SHALL pulse next cycle, partial frame SHALL be discarded, y SHALL NOT change, and the bit SHALL be taken as channel 0 of a new frame (ch=1, stay COLLECT).
REQ-019 COLLECT, din_valid=0: lanes and ch SHALL hold; an internal gap counter SHALL increment, and SHALL clear on any accepted bit.
REQ-020 GAP_LIMIT>0 and gap counter reaching GAP_LIMIT+1 in COLLECT: frame_err SHALL pulse next cycle, partial frame discarded, ch=0, state IDLE.
REQ-021 GAP_LIMIT=0: gaps of any length SHALL be tolerated.
REQ-022 Internal lanes SHALL be separate from y; y SHALL hold its value between y_valid pulses regardless of collection activity.
REQ-023 y_valid and frame_err SHALL never both be high in the same cycle.
REQ-024 Gap counter SHALL saturate and SHALL NOT wrap.
REQ-025 Bits with din_valid=0 SHALL have no effect on lanes, ch or y regardless of din/frame_start.

Reset
REQ-026 rst=1 SHALL force state IDLE, ch=0, y=16'h0000, y_valid=0, frame_err=0, busy=0, lanes and gap counter cleared, at the next rising edge.
REQ-027 Reset SHALL take priority over all inputs; a frame in progress SHALL be discarded without frame_err.
REQ-028 First bit accepted in the cycle after rst deasserts SHALL be processed normally.

Verification
REQ-029 Bench: 16 consecutive valid bits, frame_start on first, pattern 16'hA5C3 (bit k = channel k) -> y=16'hA5C3, y_valid one cycle after 16th bit, ch back to 0, busy=0.
REQ-030 Bench: same frame with din_valid low 3 cycles between channels 7 and 8, GAP_LIMIT=0 -> identical y=16'hA5C3, y_valid delayed by 3 cycles.
REQ-031 Bench: GAP_LIMIT=2, gap of 3 cycles after channel 4 -> frame_err pulse, ch=0, y unchanged, no y_valid.
REQ-032 Bench: frame_start reasserted at channel 9 then 16 full bits 16'hFFFF -> frame_err once, then y=16'hFFFF with single y_valid.
REQ-033 Bench: rst asserted at channel 12 -> y=0, ch=0, no y_valid or frame_err; next full frame 16'h0001 -> y=16'h0001.
REQ-034 Bench: back-to-back frames 16'h1234 then 16'h8001, no idle cycle -> two y_valid pulses 16 cycles apart, correct values.
